dmi_req_sequencer: RTL and testbench

Sequences single DMI accesses between the UART debug TAP and the RISC-V debug module. It converts the TAP's level-held read/write request into a valid/ready request and response handshake on the debug-module DMI port, and returns the response to the TAP with a done strobe. It also tracks sticky DMI errors, applies a per-phase timeout, and generates the debug-module hard reset. It sits between the TAP's DMI interface and the debug module's DMI request/response ports.

---
 rtl/dmi_req_sequencer_if.sv | 32 +++
 rtl/dmi_req_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_dmi_req_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_req_sequencer_if.sv
// DMI request/response handshake between the access sequencer and the
// debug module. Ports: req_valid/req_ready/req, resp_valid/resp_ready/resp.
interface dmi_req_sequencer_if #(
  parameter int ABITS = 7
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ABITS+33:0] req;
  logic              resp_valid;
  logic              resp_ready;
  logic [33:0]       resp;

  modport master (
    output req_valid,
    output req,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp
  );

  modport slave (
    input  req_valid,
    input  req,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp
  );

endinterface

// File: rtl/dmi_req_sequencer.sv
// Sequences one DMI access from the TAP's level-held request onto the DM
// valid/ready port. Ports: CLK_I, RST_I (async, high), HARD_RESET_I,
// ERROR_CLR_I, DMI_READ_I, DMI_WRITE_I, DMI_I, DMI_O, DMI_DONE_O,
// DMI_ERROR_O, DM_RST_NO, dm (request/response handshake, master side).
module dmi_req_sequencer #(
  parameter int ABITS          = 7,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int RESET_CYCLES   = 16
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              HARD_RESET_I,
  input  logic              ERROR_CLR_I,
  input  logic              DMI_READ_I,
  input  logic              DMI_WRITE_I,
  input  logic [ABITS+33:0] DMI_I,
  output logic [ABITS+33:0] DMI_O,
  output logic              DMI_DONE_O,
  output logic [1:0]        DMI_ERROR_O,
  output logic              DM_RST_NO,
  dmi_req_sequencer_if.master dm
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  localparam logic [2:0] ST_RESET    = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_REQUEST  = 3'd2;
  localparam logic [2:0] ST_RESPONSE = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_d;
  logic [TW-1:0]     to_cnt;
  logic [TW-1:0]     to_cnt_d;
  logic [RW-1:0]     rst_cnt;
  logic [RW-1:0]     rst_cnt_d;
  logic [ABITS+33:0] req_q;
  logic [ABITS+33:0] req_d;
  logic [ABITS+33:0] dmi_q;
  logic [ABITS+33:0] dmi_d;
  logic [1:0]        err_q;
  logic [1:0]        err_d;
  logic [1:0]        err_set;

  logic is_reset;
  logic is_idle;
  logic is_request;
  logic is_response;
  logic is_done;

  logic              timeout;
  logic [ABITS-1:0]  tap_addr;
  logic [ABITS-1:0]  cur_addr;
  logic [ABITS+33:0] busy_word;
  logic [1:0]        resp_err;
  logic              unused_op;

  assign is_reset    = (state == ST_RESET);
  assign is_idle     = (state == ST_IDLE);
  assign is_request  = (state == ST_REQUEST);
  assign is_response = (state == ST_RESPONSE);
  assign is_done     = (state == ST_DONE);

  assign timeout   = (to_cnt == TO_LAST);
  assign tap_addr  = DMI_I[ABITS+33:34];
  assign cur_addr  = req_q[ABITS+33:34];
  assign busy_word = {cur_addr, 2'b11, 32'h0};
  assign unused_op = ^DMI_I[33:32];

  // resp 2 -> failed (10), resp 3 -> busy (11), 0/1 -> no error
  assign resp_err = dm.resp[1] ? dm.resp[1:0] : 2'b00;

  always_comb begin
    state_d   = state;
    to_cnt_d  = '0;
    rst_cnt_d = '0;
    req_d     = req_q;
    dmi_d     = dmi_q;
    err_set   = 2'b00;
    if (HARD_RESET_I && !is_reset) begin
      state_d = ST_RESET;
    end else begin
      unique case (1'b1)
        is_reset: begin
          dmi_d     = '0;
          rst_cnt_d = rst_cnt + 1'b1;
          if (rst_cnt == RST_LAST) begin
            state_d = ST_IDLE;
          end
        end
        is_idle: begin
          if (DMI_READ_I) begin
            req_d   = {tap_addr, 2'b01, 32'h0};
            state_d = ST_REQUEST;
          end else if (DMI_WRITE_I) begin
            req_d   = {tap_addr, 2'b10, DMI_I[31:0]};
            state_d = ST_REQUEST;
          end
        end
        is_request: begin
          to_cnt_d = to_cnt + 1'b1;
          // handshake beats a timeout landing on the same cycle
          if (dm.req_ready) begin
            to_cnt_d = '0;
            state_d  = ST_RESPONSE;
          end else if (timeout) begin
            dmi_d   = busy_word;
            err_set = 2'b11;
            state_d = ST_DONE;
          end
        end
        is_response: begin
          to_cnt_d = to_cnt + 1'b1;
          if (dm.resp_valid) begin
            dmi_d   = {cur_addr, dm.resp[1:0], dm.resp[33:2]};
            err_set = resp_err;
            state_d = ST_DONE;
          end else if (timeout) begin
            dmi_d   = busy_word;
            err_set = 2'b11;
            state_d = ST_DONE;
          end
        end
        is_done: begin
          if (!DMI_READ_I && !DMI_WRITE_I) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  // first error sticks; a new error in the clear cycle still lands
  always_comb begin
    err_d = err_q;
    if (is_reset) begin
      err_d = 2'b00;
    end else if (err_set != 2'b00 &&
                 (err_q == 2'b00 || ERROR_CLR_I)) begin
      err_d = err_set;
    end else if (ERROR_CLR_I) begin
      err_d = 2'b00;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state   <= ST_RESET;
      to_cnt  <= '0;
      rst_cnt <= '0;
      req_q   <= '0;
      dmi_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      state   <= state_d;
      to_cnt  <= to_cnt_d;
      rst_cnt <= rst_cnt_d;
      req_q   <= req_d;
      dmi_q   <= dmi_d;
      err_q   <= err_d;
    end
  end

  assign DMI_O         = dmi_q;
  assign DMI_DONE_O    = is_done;
  assign DMI_ERROR_O   = err_q;
  assign DM_RST_NO     = !is_reset;
  assign dm.req_valid  = is_request;
  assign dm.req        = req_q;
  assign dm.resp_ready = is_response;

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Bench for dmi_req_sequencer: directed accesses, timeouts, sticky
// errors, hard reset and async reset against a transaction-level model.
module tb_dmi_req_sequencer;

  localparam int AB = 7;
  localparam int TO = 8;
  localparam int RC = 5;
  localparam int W  = AB + 34;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hard_rst = 1'b0;
  logic         err_clr = 1'b0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [W-1:0] dmi_i = '0;
  logic [W-1:0] dmi_o;
  logic         done;
  logic [1:0]   err;
  logic         dm_rst_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmi_req_sequencer_if #(.ABITS(AB)) dm ();

  dmi_req_sequencer #(
    .ABITS(AB),
    .TIMEOUT_CYCLES(TO),
    .RESET_CYCLES(RC)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .HARD_RESET_I(hard_rst),
    .ERROR_CLR_I(err_clr),
    .DMI_READ_I(rd),
    .DMI_WRITE_I(wr),
    .DMI_I(dmi_i),
    .DMI_O(dmi_o),
    .DMI_DONE_O(done),
    .DMI_ERROR_O(err),
    .DM_RST_NO(dm_rst_n),
    .dm(dm)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: which phase of an access the TAP/DM exchange is in, plus
  // the words and error the rules say must be visible.
  typedef enum int {P_RST, P_IDLE, P_REQ, P_RESP, P_DONE} ph_t;
  ph_t          ph = P_RST;
  int           waitc = 0;
  int           rstc = 0;
  logic [W-1:0] m_req = '0;
  logic [W-1:0] m_out = '0;
  logic [1:0]   m_err = 2'b00;

  function automatic logic [1:0] code_err(input logic [1:0] r);
    if (r == 2'b10) return 2'b10;
    if (r == 2'b11) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0] set_e;
    logic       was_rst;
    set_e   = 2'b00;
    was_rst = (ph == P_RST);
    if (rst) begin
      ph    = P_RST;
      rstc  = 0;
      waitc = 0;
      m_req = '0;
      m_out = '0;
      m_err = 2'b00;
    end else if (hard_rst && ph != P_RST) begin
      ph   = P_RST;
      rstc = 0;
      if (err_clr) m_err = 2'b00;
    end else begin
      case (ph)
        P_RST: begin
          rstc++;
          m_out = '0;
          if (rstc == RC) ph = P_IDLE;
        end
        P_IDLE: begin
          waitc = 0;
          if (rd) begin
            m_req = {dmi_i[W-1:34], 2'b01, 32'h0};
            ph    = P_REQ;
          end else if (wr) begin
            m_req = {dmi_i[W-1:34], 2'b10, dmi_i[31:0]};
            ph    = P_REQ;
          end
        end
        P_REQ: begin
          waitc++;
          if (dm.req_ready) begin
            ph    = P_RESP;
            waitc = 0;
          end else if (waitc == TO) begin
            m_out = {m_req[W-1:34], 2'b11, 32'h0};
            set_e = 2'b11;
            ph    = P_DONE;
          end
        end
        P_RESP: begin
          waitc++;
          if (dm.resp_valid) begin
            m_out = {m_req[W-1:34], dm.resp[1:0], dm.resp[33:2]};
            set_e = code_err(dm.resp[1:0]);
            ph    = P_DONE;
          end else if (waitc == TO) begin
            m_out = {m_req[W-1:34], 2'b11, 32'h0};
            set_e = 2'b11;
            ph    = P_DONE;
          end
        end
        P_DONE: begin
          if (!rd && !wr) ph = P_IDLE;
        end
        default: ;
      endcase
      if (was_rst) m_err = 2'b00;
      else if (set_e != 2'b00 && (m_err == 2'b00 || err_clr)) m_err = set_e;
      else if (err_clr) m_err = 2'b00;
    end
  end

  always @(negedge clk) begin
    chk("dm_rst_n", dm_rst_n, ph != P_RST);
    chk("req_valid", dm.req_valid, ph == P_REQ);
    chk("resp_ready", dm.resp_ready, ph == P_RESP);
    chk("done", done, ph == P_DONE);
    chk("dmi_o", dmi_o, m_out);
    chk("err", err, m_err);
    if (ph == P_REQ) chk("req_o", dm.req, m_req);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) chk({nm, " done bound"}, 0, 1);
  endtask

  task automatic wait_rst(output int n);
    n = 0;
    while (!dm_rst_n && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    dm.req_ready  = 1'b0;
    dm.resp_valid = 1'b0;
    dm.resp       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst dmi_o", dmi_o, 0);
    chk("rst req_o", dm.req, 0);
    chk("rst dm_rst_n", dm_rst_n, 0);
    chk("rst err", err, 0);
    #1 rst = 1'b0;
    wait_rst(n);
    chk("rst release len", n, RC);

    // read, DM always ready
    dm.req_ready  = 1'b1;
    dm.resp_valid = 1'b1;
    dm.resp       = {32'hDEADBEEF, 2'b00};
    dmi_i         = {7'h11, 2'b00, 32'h0};
    rd            = 1'b1;
    wait_done("t1", n);
    chk("t1 latency", n, 3);
    chk("t1 dmi_o", dmi_o, {7'h11, 2'b00, 32'hDEADBEEF});
    chk("t1 err", err, 0);
    rd = 1'b0;
    dm.resp_valid = 1'b0;
    tick();
    chk("t1 done drop", done, 0);

    // write, ready delayed 5 cycles
    dm.req_ready = 1'b0;
    dmi_i = {7'h10, 2'b00, 32'h80000001};
    wr = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t2 req_valid", dm.req_valid, 1);
      chk("t2 req_o", dm.req, {7'h10, 2'b10, 32'h80000001});
      if (i == 5) dm.req_ready = 1'b1;
      tick();
    end
    dm.req_ready = 1'b0;
    chk("t2 resp_ready", dm.resp_ready, 1);
    tick();
    tick();
    dm.resp = {32'h0000CAFE, 2'b00};
    dm.resp_valid = 1'b1;
    wait_done("t2", n);
    chk("t2 dmi_o", dmi_o, {7'h10, 2'b00, 32'h0000CAFE});
    dm.resp_valid = 1'b0;
    wr = 1'b0;
    tick();

    // request timeout
    dmi_i = {7'h05, 2'b00, 32'h0};
    rd = 1'b1;
    tick();
    c = 0;
    while (dm.req_valid && c < 40) begin
      c++;
      tick();
    end
    chk("t3 req cycles", c, TO);
    chk("t3 done", done, 1);
    chk("t3 dmi_o", dmi_o, {7'h05, 2'b11, 32'h0});
    chk("t3 err", err, 2'b11);
    rd = 1'b0;
    tick();

    // later failed response keeps first error
    dm.req_ready  = 1'b1;
    dm.resp_valid = 1'b1;
    dm.resp       = {32'h00001234, 2'b10};
    dmi_i         = {7'h06, 2'b00, 32'h0};
    rd            = 1'b1;
    wait_done("t3b", n);
    chk("t3b dmi_o", dmi_o, {7'h06, 2'b10, 32'h00001234});
    chk("t3b err sticky", err, 2'b11);
    rd = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3 err cleared", err, 0);
    rd = 1'b1;
    wait_done("t3c", n);
    chk("t3c err failed", err, 2'b10);
    rd = 1'b0;
    dm.resp_valid = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // ready on the last wait cycle wins, then response timeout
    dm.req_ready = 1'b0;
    dmi_i = {7'h07, 2'b00, 32'h0};
    rd = 1'b1;
    tick();
    repeat (TO - 1) tick();
    dm.req_ready = 1'b1;
    tick();
    dm.req_ready = 1'b0;
    chk("t4 resp_ready", dm.resp_ready, 1);
    chk("t4 no done", done, 0);
    chk("t4 no err", err, 0);
    c = 0;
    while (dm.resp_ready && c < 40) begin
      c++;
      tick();
    end
    chk("t4 resp cycles", c, TO);
    chk("t4 dmi_o", dmi_o, {7'h07, 2'b11, 32'h0});
    chk("t4 err", err, 2'b11);
    rd = 1'b0;
    tick();

    // hard reset while waiting for a response
    dm.req_ready = 1'b1;
    dmi_i = {7'h08, 2'b00, 32'h0};
    rd = 1'b1;
    tick();
    tick();
    chk("t5 in resp", dm.resp_ready, 1);
    hard_rst = 1'b1;
    tick();
    hard_rst = 1'b0;
    rd = 1'b0;
    chk("t5 req_valid", dm.req_valid, 0);
    chk("t5 resp_ready", dm.resp_ready, 0);
    chk("t5 dm_rst_n", dm_rst_n, 0);
    wait_rst(n);
    chk("t5 rst len", n, RC);
    chk("t5 err", err, 0);
    chk("t5 dmi_o", dmi_o, 0);
    dm.resp_valid = 1'b1;
    dm.resp = {32'h55AA55AA, 2'b01};
    dmi_i = {7'h09, 2'b00, 32'h0};
    rd = 1'b1;
    wait_done("t5b", n);
    chk("t5b latency", n, 3);
    chk("t5b dmi_o", dmi_o, {7'h09, 2'b01, 32'h55AA55AA});
    rd = 1'b0;
    dm.resp_valid = 1'b0;
    tick();

    // async reset mid-access
    dm.req_ready = 1'b0;
    dmi_i = {7'h0A, 2'b00, 32'h0};
    rd = 1'b1;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("t6 req_valid", dm.req_valid, 0);
    chk("t6 resp_ready", dm.resp_ready, 0);
    chk("t6 done", done, 0);
    chk("t6 dmi_o", dmi_o, 0);
    chk("t6 req_o", dm.req, 0);
    chk("t6 dm_rst_n", dm_rst_n, 0);
    rd = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_rst(n);
    chk("t6 rst len", n, RC);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
